regfile_access_ctrl: RTL and testbench

//   Front-end scheduler for the 32x32 register file. Regfile does one op per enabled

---
 rtl/regfile_access_ctrl_pkg.sv | 19 +
 rtl/regfile_access_ctrl_wb_fifo.sv | 68 ++++++
 rtl/regfile_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared constants for the register-file front end: default widths, FSM state
// encodings and regfile op encodings.
// No logic; imported by regfile_access_ctrl and its writeback FIFO.
package regfile_access_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int WB_DEPTH = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Value driven on rf_rw when the regfile port is enabled
    localparam logic RF_RD = 1'b0;
    localparam logic RF_WR = 1'b1;

endpackage

// File: rtl/regfile_access_ctrl_wb_fifo.sv
// Purpose: writeback buffer in front of the regfile port; exposes every entry's rd for hazard checks.
// Latency: a push is visible as head / entry-valid one cycle later; a pop takes effect at the clock edge.
// Backpressure: caller must not push when o_full or pop when o_empty; o_full comes straight from registered pointers.
// Ports: i_clk/i_reset (sync, active-low flush), i_push/i_push_rd/i_push_data, i_pop,
//        o_full/o_empty, o_head_rd/o_head_data, o_ent_rd/o_ent_vld (per-slot rd and valid).
module regfile_access_ctrl_wb_fifo #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [AW-1:0]              i_push_rd,
    input  logic [XLEN-1:0]            i_push_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [AW-1:0]              o_head_rd,
    output logic [XLEN-1:0]            o_head_data,
    output logic [DEPTH-1:0][AW-1:0]   o_ent_rd,
    output logic [DEPTH-1:0]           o_ent_vld
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [PW:0]                r_wr_ptr;
    logic [PW:0]                r_rd_ptr;
    logic [DEPTH-1:0][AW-1:0]   r_rd;
    logic [DEPTH-1:0][XLEN-1:0] r_data;
    logic [DEPTH-1:0]           r_vld;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
        end else begin
            // Push and pop never target the same slot: that would need the FIFO
            // to be full on push or empty on pop, both excluded by the caller.
            if (i_pop) begin
                r_rd_ptr                 <= r_rd_ptr + (PW+1)'(1);
                r_vld[r_rd_ptr[PW-1:0]]  <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr                 <= r_wr_ptr + (PW+1)'(1);
                r_vld[r_wr_ptr[PW-1:0]]  <= 1'b1;
            end
        end
    end

    // Payload needs no reset: r_vld gates every use of it
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_rd[r_wr_ptr[PW-1:0]]   <= i_push_rd;
            r_data[r_wr_ptr[PW-1:0]] <= i_push_data;
        end
    end

    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign o_head_rd   = r_rd[r_rd_ptr[PW-1:0]];
    assign o_head_data = r_data[r_rd_ptr[PW-1:0]];
    assign o_ent_rd    = r_rd;
    assign o_ent_vld   = r_vld;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Purpose: merges writebacks and decode reads onto the single regfile port, with RAW stalls and post-reset clear.
// Latency: read accepted in cycle N -> operands on o_rsp_* in N+1; writeback accepted in N readable from N+2.
// Backpressure: o_wb_ready drops when the FIFO is full; o_rd_ready drops on a RAW hazard or a full FIFO (write forced).
// Ports: i_clk, i_reset (sync active-low); decode read i_rd_*/o_rd_ready, response o_rsp_*;
//        writeback i_wb_*/o_wb_ready; regfile side o_rf_* (rs1/rs2/rd/din/enable/rw/reset) and i_rf_out1/2.
module regfile_access_ctrl #(
    parameter int XLEN     = regfile_access_ctrl_pkg::XLEN,
    parameter int AW       = regfile_access_ctrl_pkg::AW,
    parameter int WB_DEPTH = regfile_access_ctrl_pkg::WB_DEPTH
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rd_valid,
    output logic            o_rd_ready,
    input  logic [AW-1:0]   i_rd_rs1,
    input  logic [AW-1:0]   i_rd_rs2,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_data1,
    output logic [XLEN-1:0] o_rsp_data2,
    input  logic            i_wb_valid,
    output logic            o_wb_ready,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [AW-1:0]   o_rf_rs1,
    output logic [AW-1:0]   o_rf_rs2,
    output logic [AW-1:0]   o_rf_rd,
    output logic [XLEN-1:0] o_rf_din,
    output logic            o_rf_enable,
    output logic            o_rf_rw,
    output logic            o_rf_reset,
    input  logic [XLEN-1:0] i_rf_out1,
    input  logic [XLEN-1:0] i_rf_out2
);

    import regfile_access_ctrl_pkg::*;

    state_t                       r_state;
    logic                         r_rsp_valid;

    logic                         w_run;
    logic                         w_init;
    logic                         w_full;
    logic                         w_empty;
    logic [AW-1:0]                w_head_rd;
    logic [XLEN-1:0]              w_head_data;
    logic [WB_DEPTH-1:0][AW-1:0]  w_ent_rd;
    logic [WB_DEPTH-1:0]          w_ent_vld;
    logic                         w_wb_acc;
    logic                         w_wb_push;
    logic                         w_hazard;
    logic                         w_rd_acc;
    logic                         w_pop;

    // Reset input is folded in combinationally so the handshakes and the clear
    // are correct in the very cycle reset is asserted.
    assign w_run  = i_reset && (r_state == ST_RUN);
    assign w_init = !i_reset || (r_state == ST_INIT);

    // Full is taken from registered pointers only, so a full FIFO never
    // accepts a push even in a cycle that pops.
    assign o_wb_ready = w_run && !w_full;
    assign w_wb_acc   = i_wb_valid && o_wb_ready;
    // x0 writes are acknowledged but dropped here
    assign w_wb_push  = w_wb_acc && (i_wb_rd != '0);

    // A source of x0 can never match: x0 is never pushed and w_wb_push excludes it.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (w_ent_vld[i] && (w_ent_rd[i] == i_rd_rs1 || w_ent_rd[i] == i_rd_rs2)) begin
                w_hazard = 1'b1;
            end
        end
        // The same-cycle writeback is older than this read
        if (w_wb_push && (i_wb_rd == i_rd_rs1 || i_wb_rd == i_rd_rs2)) begin
            w_hazard = 1'b1;
        end
    end

    // A full FIFO blocks reads so the write drains and any stalled read's
    // hazard is guaranteed to clear.
    assign o_rd_ready = w_run && !w_hazard && !w_full;
    assign w_rd_acc   = i_rd_valid && o_rd_ready;
    assign w_pop      = w_run && !w_rd_acc && !w_empty;

    regfile_access_ctrl_wb_fifo #(
        .XLEN  (XLEN),
        .AW    (AW),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_wb_push),
        .i_push_rd   (i_wb_rd),
        .i_push_data (i_wb_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_ent_rd    (w_ent_rd),
        .o_ent_vld   (w_ent_vld)
    );

    // Regfile op is driven in the accept cycle so read data lands one cycle later
    always_comb begin
        o_rf_enable = 1'b0;
        o_rf_reset  = 1'b0;
        o_rf_rw     = RF_RD;
        o_rf_rs1    = '0;
        o_rf_rs2    = '0;
        o_rf_rd     = '0;
        o_rf_din    = '0;
        if (w_init) begin
            o_rf_enable = 1'b1;
            o_rf_reset  = 1'b1;
        end else if (w_rd_acc) begin
            o_rf_enable = 1'b1;
            o_rf_rs1    = i_rd_rs1;
            o_rf_rs2    = i_rd_rs2;
        end else if (w_pop) begin
            o_rf_enable = 1'b1;
            o_rf_rw     = RF_WR;
            o_rf_rd     = w_head_rd;
            o_rf_din    = w_head_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_INIT;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
            r_rsp_valid <= w_rd_acc;
        end
    end

    // Gating with the reset input suppresses a response due in a reset cycle
    assign o_rsp_valid = r_rsp_valid && i_reset;
    assign o_rsp_data1 = i_rf_out1;
    assign o_rsp_data2 = i_rf_out2;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_rs1, rd_rs2;
    logic        rsp_valid;
    logic [31:0] rsp_data1, rsp_data2;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_din;
    logic        rf_enable, rf_rw, rf_reset;
    logic [31:0] rf_out1, rf_out2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_access_ctrl dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rd_valid  (rd_valid),
        .o_rd_ready  (rd_ready),
        .i_rd_rs1    (rd_rs1),
        .i_rd_rs2    (rd_rs2),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data1 (rsp_data1),
        .o_rsp_data2 (rsp_data2),
        .i_wb_valid  (wb_valid),
        .o_wb_ready  (wb_ready),
        .i_wb_rd     (wb_rd),
        .i_wb_data   (wb_data),
        .o_rf_rs1    (rf_rs1),
        .o_rf_rs2    (rf_rs2),
        .o_rf_rd     (rf_rd),
        .o_rf_din    (rf_din),
        .o_rf_enable (rf_enable),
        .o_rf_rw     (rf_rw),
        .o_rf_reset  (rf_reset),
        .i_rf_out1   (rf_out1),
        .i_rf_out2   (rf_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 32x32 regfile; filled with junk first so the clear is observable
    logic [31:0] mem [32];
    logic        fill_req = 1'b1;
    int          wr_cnt = 0;
    logic        bad_rsp = 1'b0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
            fill_req <= 1'b0;
        end else if (rf_enable) begin
            if (rf_reset) begin
                for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            end else if (rf_rw) begin
                mem[rf_rd] <= rf_din;
                wr_cnt     <= wr_cnt + 1;
            end else begin
                rf_out1 <= mem[rf_rs1];
                rf_out2 <= mem[rf_rs2];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n && rsp_valid) bad_rsp <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a read until accepted (bounded), then capture the response cycle
    task automatic rd_op(input logic [4:0] a, input logic [4:0] b,
                         output logic [31:0] d1, output logic [31:0] d2);
        int waited;
        rd_valid = 1'b1;
        rd_rs1   = a;
        rd_rs2   = b;
        waited   = 0;
        d1       = 32'hxxxx_xxxx;
        d2       = 32'hxxxx_xxxx;
        #1;
        while (!rd_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!rd_ready) begin
            chk("rd_accept_timeout", 32'(rd_ready), 32'd1);
            rd_valid = 1'b0;
        end else begin
            tick();
            rd_valid = 1'b0;
            chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
            d1 = rsp_data1;
            d2 = rsp_data2;
        end
    endtask

    logic [31:0] d1, d2;
    logic [31:0] vals [5];
    logic [31:0] exp1 [3];
    logic [31:0] exp2 [3];
    logic [4:0]  ra [3];
    logic [4:0]  rb [3];
    int          wr_base;

    initial begin
        vals[0] = 32'h0;
        vals[1] = 32'h1111_0001;
        vals[2] = 32'h2222_0002;
        vals[3] = 32'h3333_0003;
        vals[4] = 32'h4444_0004;

        rst_n = 1'b0; rd_valid = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        // 1: reset and clear sequencing
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_reset",  32'(rf_reset),  32'd1);
        chk("rst_rf_enable", 32'(rf_enable), 32'd1);
        chk("rst_rf_rw",     32'(rf_rw),     32'd0);
        chk("rst_rd_ready",  32'(rd_ready),  32'd0);
        chk("rst_wb_ready",  32'(wb_ready),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("init_rf_reset",  32'(rf_reset),  32'd1);
        chk("init_rf_enable", 32'(rf_enable), 32'd1);
        chk("init_rd_ready",  32'(rd_ready),  32'd0);
        tick();
        chk("run_rf_reset",  32'(rf_reset),  32'd0);
        chk("run_rf_enable", 32'(rf_enable), 32'd0);
        chk("run_wb_ready",  32'(wb_ready),  32'd1);
        rd_op(5'd5, 5'd0, d1, d2);
        chk("clear_x5", d1, 32'h0);

        // 2: write then read of the same register offered together
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        rd_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd0;
        #1;
        chk("raw_wb_ready_n",  32'(wb_ready), 32'd1);
        chk("raw_rd_ready_n",  32'(rd_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw_rd_ready_n1", 32'(rd_ready),  32'd0);
        chk("raw_wr_rw",       32'(rf_rw),     32'd1);
        chk("raw_wr_rd",       32'(rf_rd),     32'd3);
        chk("raw_wr_din",      rf_din,         32'hDEADBEEF);
        tick();
        chk("raw_rd_ready_n2", 32'(rd_ready),  32'd1);
        tick();
        rd_valid = 1'b0;
        chk("raw_rsp_valid",   32'(rsp_valid), 32'd1);
        chk("raw_rsp_data1",   rsp_data1,      32'hDEADBEEF);

        // 3: x0 writeback is acknowledged and discarded
        tick();
        wr_base = wr_cnt;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        #1;
        chk("x0_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("x0_no_issue", 32'(rf_enable), 32'd0);
        tick();
        rd_op(5'd0, 5'd0, d1, d2);
        chk("x0_data1", d1, 32'h0);
        chk("x0_data2", d2, 32'h0);
        chk("x0_no_write", 32'(wr_cnt - wr_base), 32'd0);

        // 4: fill the FIFO behind continuous reads of x10
        wr_base = wr_cnt;
        rd_valid = 1'b1; rd_rs1 = 5'd10; rd_rs2 = 5'd10;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = vals[i];
            #1;
            chk("full_wb_ready", 32'(wb_ready), 32'd1);
            chk("full_rd_wins",  32'(rf_rw),    32'd0);
            tick();
        end
        wb_valid = 1'b0;
        #1;
        chk("full_wb_ready_lo", 32'(wb_ready), 32'd0);
        chk("full_rd_ready_lo", 32'(rd_ready), 32'd0);
        chk("full_forced_rw",   32'(rf_rw),    32'd1);
        chk("full_forced_rd",   32'(rf_rd),    32'd1);
        chk("full_forced_din",  rf_din,        vals[1]);
        chk("full_x10_rsp",     rsp_data1,     32'h0);
        rd_valid = 1'b0;
        repeat (4) tick();
        chk("full_drained_en", 32'(rf_enable),           32'd0);
        chk("full_wr_count",   32'(wr_cnt - wr_base),    32'd4);
        rd_op(5'd1, 5'd2, d1, d2);
        chk("full_x1", d1, vals[1]);
        chk("full_x2", d2, vals[2]);
        rd_op(5'd3, 5'd4, d1, d2);
        chk("full_x3", d1, vals[3]);
        chk("full_x4", d2, vals[4]);

        // 5: three back-to-back reads
        ra[0] = 5'd1; rb[0] = 5'd2; exp1[0] = vals[1]; exp2[0] = vals[2];
        ra[1] = 5'd3; rb[1] = 5'd4; exp1[1] = vals[3]; exp2[1] = vals[4];
        ra[2] = 5'd5; rb[2] = 5'd6; exp1[2] = 32'h0;   exp2[2] = 32'h0;
        tick();
        for (int k = 0; k < 3; k++) begin
            rd_valid = 1'b1; rd_rs1 = ra[k]; rd_rs2 = rb[k];
            #1;
            chk("pipe_rd_ready", 32'(rd_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("pipe_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("pipe_data1",     rsp_data1,      exp1[k]);
            chk("pipe_data2",     rsp_data2,      exp2[k]);
        end
        rd_valid = 1'b0;
        tick();
        chk("pipe_rsp_end", 32'(rsp_valid), 32'd0);

        // 6: reset with writes pending and a response due
        wr_base = wr_cnt;
        rd_valid = 1'b1; rd_rs1 = 5'd10; rd_rs2 = 5'd10;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h7777_7777;
        tick();
        wb_data = 32'h8888_8888;
        tick();
        rd_valid = 1'b0; wb_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_suppr", 32'(rsp_valid), 32'd0);
        chk("mid_rd_ready",  32'(rd_ready),  32'd0);
        chk("mid_wb_ready",  32'(wb_ready),  32'd0);
        chk("mid_rf_reset",  32'(rf_reset),  32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_init_reset", 32'(rf_reset),  32'd1);
        chk("mid_init_rsp",   32'(rsp_valid), 32'd0);
        tick();
        chk("mid_run_idle", 32'(rf_enable), 32'd0);
        rd_op(5'd7, 5'd0, d1, d2);
        chk("mid_x7_zero",   d1,                   32'h0);
        chk("mid_no_writes", 32'(wr_cnt - wr_base), 32'd0);
        chk("no_rsp_in_reset", 32'(bad_rsp),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
